// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N_REQ requesters.
// Each grant sends {SYNC_NIBBLE, id}, the payload LSB-first, then an optional XOR checksum.
module uart_tx_sched #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DATA_BYTES   = 4,
    parameter bit          CHECKSUM_EN  = 1'b1,
    parameter logic [3:0]  SYNC_NIBBLE  = 4'hA,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                          i_sys_clk,
    input  logic                          i_rst_n,
    input  logic [N_REQ-1:0]              i_req,
    input  logic [N_REQ*DATA_BYTES*8-1:0] i_req_data,
    output logic [N_REQ-1:0]              o_grant,
    output logic                          o_tx_dv,
    output logic [7:0]                    o_tx_byte,
    input  logic                          i_tx_done,
    output logic                          o_busy,
    output logic                          o_frame_done,
    output logic                          o_err
);

    localparam int unsigned NBytes = 1 + DATA_BYTES + (CHECKSUM_EN ? 1 : 0);
    localparam int unsigned CntW   = $clog2(12 * CLKS_PER_BIT + 1);
    localparam int unsigned IdW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned IdxW   = $clog2(NBytes + 1);
    localparam int unsigned WordW  = DATA_BYTES * 8;
    localparam logic [CntW-1:0] InitLast   = CntW'(11 * CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(12 * CLKS_PER_BIT);

    typedef enum logic [2:0] {StInit, StIdle, StSend, StWaitHi, StWaitLo} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [IdW-1:0]   ptr_q;
    logic [IdxW-1:0]  idx_q;
    logic [7:0]       csum_q;
    logic [WordW-1:0] word_q;
    logic             last_q;
    logic [N_REQ-1:0] grant_q;
    logic             tx_dv_q;
    logic [7:0]       tx_byte_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             err_q;

    logic             pick_valid;
    logic [IdW-1:0]   pick_id;
    logic [IdW-1:0]   ptr_next;
    logic [7:0]       hdr;
    logic [IdxW-1:0]  nidx;
    logic             more;
    logic [7:0]       next_byte;
    logic [7:0]       csum_next;
    logic [CntW-1:0]  cnt_inc;
    logic             timeout;

    // Scan from the highest offset down so the lowest offset from ptr_q wins.
    always_comb begin
        int c;
        c          = 0;
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            c = (int'(ptr_q) + k) % int'(N_REQ);
            if (i_req[c]) begin
                pick_valid = 1'b1;
                pick_id    = IdW'(c);
            end
        end
        ptr_next = (pick_id == IdW'(N_REQ - 1)) ? '0 : pick_id + 1'b1;
        hdr      = {SYNC_NIBBLE, 4'(pick_id)};
    end

    // Byte that follows the one just completed; past the payload it is the checksum.
    always_comb begin
        nidx      = idx_q + 1'b1;
        more      = (nidx < IdxW'(NBytes));
        next_byte = csum_q;
        csum_next = csum_q;
        if (nidx <= IdxW'(DATA_BYTES)) begin
            next_byte = word_q[8*(int'(nidx)-1) +: 8];
            csum_next = csum_q ^ next_byte;
        end
        cnt_inc = cnt_q + 1'b1;
        timeout = (cnt_inc == TimeoutVal);
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StInit;
            cnt_q        <= '0;
            ptr_q        <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            grant_q      <= '0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= '0;
            busy_q       <= 1'b1;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            grant_q      <= '0;
            tx_dv_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            unique case (state_q)
                StInit: begin
                    if (cnt_q == InitLast) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StIdle: begin
                    if (pick_valid) begin
                        word_q    <= i_req_data[pick_id*WordW +: WordW];
                        grant_q   <= N_REQ'(1) << pick_id;
                        ptr_q     <= ptr_next;
                        csum_q    <= hdr;
                        tx_byte_q <= hdr;
                        idx_q     <= '0;
                        last_q    <= 1'b0;
                        tx_dv_q   <= 1'b1;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StSend;
                    end
                end
                StSend: begin
                    cnt_q   <= cnt_inc;
                    state_q <= StWaitHi;
                end
                StWaitHi, StWaitLo: begin
                    if (timeout) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StInit;
                    end else if (state_q == StWaitHi) begin
                        cnt_q <= cnt_inc;
                        if (i_tx_done) begin
                            idx_q   <= nidx;
                            state_q <= StWaitLo;
                            if (more) begin
                                tx_byte_q <= next_byte;
                                csum_q    <= csum_next;
                            end else begin
                                frame_done_q <= 1'b1;
                                last_q       <= 1'b1;
                            end
                        end
                    end else if (!i_tx_done) begin
                        // uart_tx is back in idle only once done has dropped
                        if (last_q) begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            tx_dv_q <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= StSend;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign o_grant      = grant_q;
    assign o_tx_dv      = tx_dv_q;
    assign o_tx_byte    = tx_byte_q;
    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: two instances (4x2-byte with checksum, 4x1-byte without)
// each driving a cycle-level uart_tx stand-in that raises done for 2 cycles per byte.
module tb_uart_tx_sched;

    localparam int unsigned Cpb = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  req_a  = '0;
    logic [63:0] data_a = '0;
    logic [3:0]  grant_a;
    logic        dv_a, done_a, busy_a, fd_a, err_a;
    logic [7:0]  byte_a;

    logic [3:0]  req_b  = '0;
    logic [31:0] data_b = '0;
    logic [3:0]  grant_b;
    logic        dv_b, done_b, busy_b, fd_b, err_b;
    logic [7:0]  byte_b;

    logic kill = 1'b0;
    int   m_cnt[2] = '{0, 0};
    int   cyc = 0;

    uart_tx_sched #(.N_REQ(4), .DATA_BYTES(2), .CHECKSUM_EN(1'b1), .SYNC_NIBBLE(4'hA),
                    .CLKS_PER_BIT(Cpb)) dut_a (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_req(req_a), .i_req_data(data_a),
        .o_grant(grant_a), .o_tx_dv(dv_a), .o_tx_byte(byte_a), .i_tx_done(done_a),
        .o_busy(busy_a), .o_frame_done(fd_a), .o_err(err_a)
    );

    uart_tx_sched #(.N_REQ(4), .DATA_BYTES(1), .CHECKSUM_EN(1'b0), .SYNC_NIBBLE(4'hA),
                    .CLKS_PER_BIT(Cpb)) dut_b (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_req_data(data_b),
        .o_grant(grant_b), .o_tx_dv(dv_b), .o_tx_byte(byte_b), .i_tx_done(done_b),
        .o_busy(busy_b), .o_frame_done(fd_b), .o_err(err_b)
    );

    // uart_tx stand-in: 10 bit times of line activity, then done high for two cycles
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int u = 0; u < 2; u++) begin
            if (m_cnt[u] != 0) m_cnt[u] <= m_cnt[u] - 1;
            else if ((u == 0) ? dv_a : dv_b) m_cnt[u] <= 10 * Cpb + 2;
        end
    end
    assign done_a = ((m_cnt[0] == 1) || (m_cnt[0] == 2)) && !kill;
    assign done_b = (m_cnt[1] == 1) || (m_cnt[1] == 2);

    logic [7:0] bytes_a[$];
    logic [7:0] bytes_b[$];
    logic [3:0] grants_a[$];
    logic [7:0] hdrs_a[$];
    int n_dv_a = 0, n_dv_hi_a = 0, n_fd_a = 0, n_err_a = 0;
    int n_dv_b = 0, n_fd_b = 0, n_rise_b = 0, rise_at_fd_b = 0;
    logic done_b_prev = 1'b0;

    always @(negedge clk) begin
        if (dv_a) begin
            bytes_a.push_back(byte_a);
            n_dv_a++;
            if (done_a) n_dv_hi_a++;
        end
        if (grant_a != 4'b0) begin
            grants_a.push_back(grant_a);
            hdrs_a.push_back(byte_a);
        end
        if (fd_a) n_fd_a++;
        if (err_a) n_err_a++;
        if (dv_b) begin
            bytes_b.push_back(byte_b);
            n_dv_b++;
        end
        if (done_b && !done_b_prev) n_rise_b++;
        done_b_prev = done_b;
        if (fd_b) begin
            n_fd_b++;
            rise_at_fd_b = n_rise_b;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant_a), 0);
        check({tag, "_dv"}, 32'(dv_a), 0);
        check({tag, "_byte"}, 32'(byte_a), 0);
        check({tag, "_fd"}, 32'(fd_a), 0);
        check({tag, "_err"}, 32'(err_a), 0);
        check({tag, "_busy"}, 32'(busy_a), 1);
    endtask

    initial begin
        int n, base, t0, t1, fd0;

        // Reset state, then the INIT wait
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        check("rst_busy_b", 32'(busy_b), 1);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 44; i++) begin
            #1 n += int'(busy_a);
            @(negedge clk);
        end
        check("init_busy_cycles", n, 44);
        #1 check("init_idle", 32'(busy_a), 0);
        check("init_no_dv", n_dv_a, 0);

        // Single frame from requester 1
        req_a = 4'b0010;
        data_a[31:16] = 16'hBEEF;
        @(negedge clk);
        check("f1_grant", 32'(grant_a), 32'h2);
        check("f1_dv", 32'(dv_a), 1);
        check("f1_hdr", 32'(byte_a), 32'hA1);
        req_a = 4'b0000;
        data_a[31:16] = 16'h1234;
        @(negedge clk);
        check("f1_grant_pulse", 32'(grant_a), 0);
        for (int i = 0; i < 400 && busy_a; i++) @(negedge clk);
        check("f1_done_idle", 32'(busy_a), 0);
        check("f1_nbytes", bytes_a.size(), 4);
        check("f1_b0", 32'(bytes_a[0]), 32'hA1);
        check("f1_b1", 32'(bytes_a[1]), 32'hEF);
        check("f1_b2", 32'(bytes_a[2]), 32'hBE);
        check("f1_csum", 32'(bytes_a[3]), 32'hF0);
        check("f1_ndv", n_dv_a, 4);
        check("f1_dv_while_done", n_dv_hi_a, 0);
        check("f1_nfd", n_fd_a, 1);
        check("f1_nerr", n_err_a, 0);

        // Reset to put the pointer at 0, then all four requesting for five frames
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100 && busy_a; i++) @(negedge clk);
        base = grants_a.size();
        req_a  = 4'b1111;
        data_a = 64'h4444_3333_2222_1111;
        for (int i = 0; i < 2000 && grants_a.size() < base + 5; i++) @(negedge clk);
        req_a = 4'b0000;
        for (int i = 0; i < 400 && busy_a; i++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_grant%0d", k), 32'(grants_a[base+k]), 32'(1 << (k % 4)));
            check($sformatf("rr_hdr%0d", k), 32'(hdrs_a[base+k]), 32'hA0 + 32'(k % 4));
        end

        // Timeout: done never returns for requester 1's header byte
        fd0 = n_fd_a;
        req_a = 4'b0010;
        @(negedge clk);
        check("to_grant", 32'(grant_a), 32'h2);
        t0 = cyc;
        kill = 1'b1;
        req_a = 4'b0110;
        for (int i = 0; i < 100 && !err_a; i++) @(negedge clk);
        check("to_err", 32'(err_a), 1);
        check("to_err_delay", cyc - t0, 48);
        check("to_no_fd", n_fd_a, fd0);
        t1 = cyc;
        kill = 1'b0;
        @(negedge clk);
        check("to_err_pulse", 32'(err_a), 0);
        for (int i = 0; i < 100 && grant_a == 4'b0; i++) @(negedge clk);
        check("to_next_grant", 32'(grant_a), 32'h4);
        check("to_reinit_delay", cyc - t1, 45);
        req_a = 4'b0000;
        for (int i = 0; i < 400 && busy_a; i++) @(negedge clk);
        check("to_nfd", n_fd_a, fd0 + 1);
        check("to_nerr", n_err_a, 1);

        // Asynchronous reset during a payload byte
        base = bytes_a.size();
        req_a = 4'b1000;
        for (int i = 0; i < 200 && bytes_a.size() < base + 2; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        fd0 = n_fd_a;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && grant_a == 4'b0; i++) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_grant_delay", n, 45);
        check("mid_rst_grant", 32'(grant_a), 32'h8);
        check("mid_rst_no_fd", n_fd_a, fd0);
        req_a = 4'b0000;
        for (int i = 0; i < 400 && busy_a; i++) @(negedge clk);

        // No checksum, one payload byte of zero
        req_b = 4'b0001;
        data_b[7:0] = 8'h00;
        @(negedge clk);
        check("b_grant", 32'(grant_b), 32'h1);
        req_b = 4'b0000;
        for (int i = 0; i < 300 && busy_b; i++) @(negedge clk);
        check("b_idle", 32'(busy_b), 0);
        check("b_nbytes", bytes_b.size(), 2);
        check("b_hdr", 32'(bytes_b[0]), 32'hA0);
        check("b_payload", 32'(bytes_b[1]), 32'h00);
        check("b_ndv", n_dv_b, 2);
        check("b_nfd", n_fd_b, 1);
        check("b_fd_after_rise", rise_at_fd_b, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
